jtag_tap_responder: RTL and testbench

Soft JTAG TAP responder: receives TCK/TMS/TDI, runs the IEEE 1149.1 16-state TAP controller, decodes a 6-bit instruction register, and exposes one JDATA_WIDTH-bit user data register, plus a 1-bit bypass register, to fabric logic. It sits on the board-clock side of the JTAG pins and is the device-side counterpart of the TCK/TMS/TDI stimulus the bench drives. All JTAG inputs are oversampled on board_clock; there is no TCK clock domain inside the block.

---
 rtl/jtag_tap_responder.sv | 147 ++++++++++++++
 tb/tb_jtag_tap_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_responder.sv
// Soft JTAG TAP responder, oversampled on board_clock.
// TCK/TMS/TDI are synchronized and the TCK edges are detected in the board
// clock domain. The 16-state TAP controller advances on each detected TCK rise.
// A 6-bit IR selects either a JDATA_WIDTH user DR or the 1-bit bypass register.
module jtag_tap_responder #(
  parameter int                  JDATA_WIDTH = 32,
  parameter int                  IR_WIDTH    = 6,
  parameter logic [IR_WIDTH-1:0] USER_IR     = 6'b100011
) (
  input  logic                   board_clock,
  input  logic                   board_resetn,
  input  logic                   jtag_tck,
  input  logic                   jtag_tms,
  input  logic                   jtag_tdi,
  output logic                   jtag_tdo,
  input  logic [JDATA_WIDTH-1:0] capture_data,
  output logic [JDATA_WIDTH-1:0] jtag_data,
  output logic                   jtag_data_valid,
  output logic [3:0]             tap_state,
  output logic [IR_WIDTH-1:0]    ir_value
);

  // IEEE 1149.1 state encodings
  localparam logic [3:0] TLR     = 4'hF;
  localparam logic [3:0] RTI     = 4'hC;
  localparam logic [3:0] SEL_DR  = 4'h7;
  localparam logic [3:0] CAP_DR  = 4'h6;
  localparam logic [3:0] SH_DR   = 4'h2;
  localparam logic [3:0] EX1_DR  = 4'h1;
  localparam logic [3:0] PAU_DR  = 4'h3;
  localparam logic [3:0] EX2_DR  = 4'h0;
  localparam logic [3:0] UPD_DR  = 4'h5;
  localparam logic [3:0] SEL_IR  = 4'h4;
  localparam logic [3:0] CAP_IR  = 4'hE;
  localparam logic [3:0] SH_IR   = 4'hA;
  localparam logic [3:0] EX1_IR  = 4'h9;
  localparam logic [3:0] PAU_IR  = 4'hB;
  localparam logic [3:0] EX2_IR  = 4'h8;
  localparam logic [3:0] UPD_IR  = 4'hD;

  logic [1:0]             tck_sync, tms_sync, tdi_sync;
  logic                   tck_prev;
  logic                   tck_rise, tck_fall;
  logic                   tms_s, tdi_s;
  logic [3:0]             next_state;
  logic [IR_WIDTH-1:0]    ir_shift;
  logic [JDATA_WIDTH-1:0] dr_shift;
  logic                   byp;
  logic                   user_sel;

  // Equal-depth 2-FF synchronizers; the extra tck flop provides edge history
  always_ff @(posedge board_clock or negedge board_resetn) begin
    if (!board_resetn) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_prev <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[0], jtag_tck};
      tms_sync <= {tms_sync[0], jtag_tms};
      tdi_sync <= {tdi_sync[0], jtag_tdi};
      tck_prev <= tck_sync[1];
    end
  end

  assign tck_rise = tck_sync[1] & ~tck_prev;
  assign tck_fall = ~tck_sync[1] & tck_prev;
  assign tms_s    = tms_sync[1];
  assign tdi_s    = tdi_sync[1];
  assign user_sel = (ir_value == USER_IR);

  // TAP controller next-state function
  always_comb begin
    next_state = TLR;
    case (tap_state)
      TLR:     next_state = tms_s ? TLR    : RTI;
      RTI:     next_state = tms_s ? SEL_DR : RTI;
      SEL_DR:  next_state = tms_s ? SEL_IR : CAP_DR;
      SEL_IR:  next_state = tms_s ? TLR    : CAP_IR;
      CAP_DR:  next_state = tms_s ? EX1_DR : SH_DR;
      SH_DR:   next_state = tms_s ? EX1_DR : SH_DR;
      EX1_DR:  next_state = tms_s ? UPD_DR : PAU_DR;
      PAU_DR:  next_state = tms_s ? EX2_DR : PAU_DR;
      EX2_DR:  next_state = tms_s ? UPD_DR : SH_DR;
      UPD_DR:  next_state = tms_s ? SEL_DR : RTI;
      CAP_IR:  next_state = tms_s ? EX1_IR : SH_IR;
      SH_IR:   next_state = tms_s ? EX1_IR : SH_IR;
      EX1_IR:  next_state = tms_s ? UPD_IR : PAU_IR;
      PAU_IR:  next_state = tms_s ? EX2_IR : PAU_IR;
      EX2_IR:  next_state = tms_s ? UPD_IR : SH_IR;
      UPD_IR:  next_state = tms_s ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  // State advance and register actions, keyed to the state being left
  always_ff @(posedge board_clock or negedge board_resetn) begin
    if (!board_resetn) begin
      tap_state       <= TLR;
      ir_value        <= '1;
      ir_shift        <= '0;
      dr_shift        <= '0;
      byp             <= 1'b0;
      jtag_data       <= '0;
      jtag_data_valid <= 1'b0;
    end else begin
      jtag_data_valid <= 1'b0;
      if (tck_rise) begin
        tap_state <= next_state;
        case (tap_state)
          CAP_IR: ir_shift <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
          SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
          UPD_IR: ir_value <= ir_shift;
          CAP_DR: begin
            if (user_sel) dr_shift <= capture_data;
            else          byp      <= 1'b0;
          end
          SH_DR: begin
            if (user_sel) dr_shift <= {tdi_s, dr_shift[JDATA_WIDTH-1:1]};
            else          byp      <= tdi_s;
          end
          UPD_DR: begin
            if (user_sel) begin
              jtag_data       <= dr_shift;
              jtag_data_valid <= 1'b1;
            end
          end
          default: ;
        endcase
        // Any entry into Test-Logic-Reset falls back to bypass
        if (next_state == TLR) ir_value <= '1;
      end
    end
  end

  // TDO launches on the TCK fall so the host samples it stably on the next rise
  always_ff @(posedge board_clock or negedge board_resetn) begin
    if (!board_resetn) begin
      jtag_tdo <= 1'b0;
    end else if (tck_fall) begin
      if (tap_state == SH_IR)      jtag_tdo <= ir_shift[0];
      else if (tap_state == SH_DR) jtag_tdo <= user_sel ? dr_shift[0] : byp;
      else                         jtag_tdo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: drives TCK/TMS/TDI as a JTAG host
// and compares against hand-computed expectations.
module tb_jtag_tap_responder;

  logic        board_clock = 1'b0;
  logic        board_resetn = 1'b0;
  logic        jtag_tck = 1'b0;
  logic        jtag_tms = 1'b1;
  logic        jtag_tdi = 1'b0;
  logic        jtag_tdo;
  logic [31:0] capture_data = '0;
  logic [31:0] jtag_data;
  logic        jtag_data_valid;
  logic [3:0]  tap_state;
  logic [5:0]  ir_value;

  int errors = 0;
  int checks = 0;
  int vcount = 0;

  jtag_tap_responder dut (
    .board_clock     (board_clock),
    .board_resetn    (board_resetn),
    .jtag_tck        (jtag_tck),
    .jtag_tms        (jtag_tms),
    .jtag_tdi        (jtag_tdi),
    .jtag_tdo        (jtag_tdo),
    .capture_data    (capture_data),
    .jtag_data       (jtag_data),
    .jtag_data_valid (jtag_data_valid),
    .tap_state       (tap_state),
    .ir_value        (ir_value)
  );

  always #5 board_clock = ~board_clock;

  // Count board-clock cycles on which the update strobe is high
  always @(negedge board_clock) if (jtag_data_valid === 1'b1) vcount++;

  // One full TCK period; returns TDO as seen after the falling edge
  task automatic jclk(input logic tms_v, input logic tdi_v, output logic tdo_v);
    @(negedge board_clock);
    jtag_tms = tms_v;
    jtag_tdi = tdi_v;
    repeat (3) @(negedge board_clock);
    jtag_tck = 1'b1;
    repeat (4) @(negedge board_clock);
    jtag_tck = 1'b0;
    repeat (4) @(negedge board_clock);
    tdo_v = jtag_tdo;
  endtask

  // From RTI: full DR scan of n bits LSB-first, ends in RTI.
  // bits[k] is the TDO value presented for bit k.
  task automatic scan_dr(input logic [31:0] data, input int n, output logic [31:0] bits);
    logic t;
    bits = '0;
    jclk(1'b1, 1'b0, t);
    jclk(1'b0, 1'b0, t);
    jclk(1'b0, 1'b0, t);
    bits[0] = t;
    for (int i = 0; i < n; i++) begin
      jclk(i == n-1, data[i], t);
      if (i < n-1) bits[i+1] = t;
    end
    jclk(1'b1, 1'b0, t);
    jclk(1'b0, 1'b0, t);
  endtask

  // From RTI: IR scan LSB-first, ends in RTI
  task automatic scan_ir(input logic [5:0] data, output logic [5:0] bits);
    logic t;
    bits = '0;
    jclk(1'b1, 1'b0, t);
    jclk(1'b1, 1'b0, t);
    jclk(1'b0, 1'b0, t);
    jclk(1'b0, 1'b0, t);
    bits[0] = t;
    for (int i = 0; i < 6; i++) begin
      jclk(i == 5, data[i], t);
      if (i < 5) bits[i+1] = t;
    end
    jclk(1'b1, 1'b0, t);
    jclk(1'b0, 1'b0, t);
  endtask

  task automatic test_reset;
    logic t;
    repeat (3) @(negedge board_clock);
    board_resetn = 1'b1;
    repeat (2) @(negedge board_clock);
    checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL reset_state got %h exp f", tap_state); end
    checks++; if (ir_value !== 6'h3F) begin errors++; $display("FAIL reset_ir got %b exp 111111", ir_value); end
    checks++; if (jtag_tdo !== 1'b0 || jtag_data_valid !== 1'b0) begin errors++; $display("FAIL reset_tdo_valid got %b%b exp 00", jtag_tdo, jtag_data_valid); end
    for (int i = 0; i < 25; i++) jclk(1'b1, 1'b0, t);
    checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL tlr_state got %h exp f", tap_state); end
    checks++; if (ir_value !== 6'h3F) begin errors++; $display("FAIL tlr_ir got %b exp 111111", ir_value); end
    checks++; if (jtag_tdo !== 1'b0 || jtag_data !== 32'h0) begin errors++; $display("FAIL tlr_out got tdo=%b data=%h exp 0/0", jtag_tdo, jtag_data); end
    jclk(1'b0, 1'b0, t);
    checks++; if (tap_state !== 4'hC) begin errors++; $display("FAIL to_rti got %h exp c", tap_state); end
  endtask

  task automatic test_user_dr;
    logic [5:0]  ib;
    logic [31:0] db;
    int v0;
    scan_ir(6'b100011, ib);
    checks++; if (ir_value !== 6'b100011) begin errors++; $display("FAIL ir_load got %b exp 100011", ir_value); end
    v0 = vcount;
    scan_dr(32'hFF55AA00, 32, db);
    checks++; if (jtag_data !== 32'hFF55AA00) begin errors++; $display("FAIL dr_update got %h exp ff55aa00", jtag_data); end
    checks++; if (vcount - v0 !== 1) begin errors++; $display("FAIL dr_valid_cnt got %0d exp 1", vcount - v0); end
    checks++; if (tap_state !== 4'hC) begin errors++; $display("FAIL dr_end_state got %h exp c", tap_state); end
  endtask

  task automatic test_capture;
    logic [31:0] db;
    int v0;
    capture_data = 32'h12345678;
    v0 = vcount;
    scan_dr(32'h0, 32, db);
    capture_data = 32'h0BADF00D;
    checks++; if (db !== 32'h12345678) begin errors++; $display("FAIL capture_tdo got %h exp 12345678", db); end
    checks++; if (jtag_data !== 32'h0) begin errors++; $display("FAIL capture_data_out got %h exp 0", jtag_data); end
    checks++; if (vcount - v0 !== 1) begin errors++; $display("FAIL capture_valid_cnt got %0d exp 1", vcount - v0); end
  endtask

  task automatic test_bypass;
    logic [5:0]  ib;
    logic [31:0] db;
    int v0;
    scan_ir(6'b111111, ib);
    checks++; if (ir_value !== 6'b111111) begin errors++; $display("FAIL byp_ir got %b exp 111111", ir_value); end
    v0 = vcount;
    scan_dr(32'b1101, 4, db);
    checks++; if (db[3:0] !== 4'b1010) begin errors++; $display("FAIL byp_tdo got %b exp 1010 (0,1,0,1 lsb first)", db[3:0]); end
    checks++; if (jtag_data !== 32'h0) begin errors++; $display("FAIL byp_data got %h exp 0", jtag_data); end
    checks++; if (vcount !== v0) begin errors++; $display("FAIL byp_valid_cnt got %0d exp 0", vcount - v0); end
  endtask

  task automatic test_ir_capture;
    logic [5:0] ib;
    scan_ir(6'b100011, ib);
    checks++; if (ib[1:0] !== 2'b01) begin errors++; $display("FAIL ir_cap_tdo got %b exp 01 (1 then 0)", ib[1:0]); end
    checks++; if (ir_value !== 6'b100011) begin errors++; $display("FAIL ir_reload got %b exp 100011", ir_value); end
  endtask

  task automatic test_reset_mid_shift;
    logic [5:0]  ib;
    logic [31:0] db;
    logic        t;
    int v0;
    scan_dr(32'hDEADBEEF, 32, db);
    checks++; if (jtag_data !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_data got %h exp deadbeef", jtag_data); end
    v0 = vcount;
    jclk(1'b1, 1'b0, t);
    jclk(1'b0, 1'b0, t);
    jclk(1'b0, 1'b0, t);
    for (int i = 0; i < 10; i++) jclk(1'b0, 1'b1, t);
    checks++; if (tap_state !== 4'h2) begin errors++; $display("FAIL mid_shift_state got %h exp 2", tap_state); end
    @(negedge board_clock);
    board_resetn = 1'b0;
    #1;
    checks++; if (tap_state !== 4'hF || ir_value !== 6'h3F) begin errors++; $display("FAIL async_reset got st=%h ir=%b exp f/111111", tap_state, ir_value); end
    repeat (3) @(negedge board_clock);
    board_resetn = 1'b1;
    repeat (2) @(negedge board_clock);
    checks++; if (jtag_data !== 32'h0 || jtag_tdo !== 1'b0 || jtag_data_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out got data=%h tdo=%b v=%b exp 0", jtag_data, jtag_tdo, jtag_data_valid); end
    checks++; if (vcount !== v0) begin errors++; $display("FAIL aborted_valid_cnt got %0d exp 0", vcount - v0); end
    jclk(1'b0, 1'b0, t);
    checks++; if (tap_state !== 4'hC) begin errors++; $display("FAIL post_reset_rti got %h exp c", tap_state); end
    scan_ir(6'b100011, ib);
    v0 = vcount;
    scan_dr(32'hA5A5A5A5, 32, db);
    checks++; if (jtag_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL rescan_data got %h exp a5a5a5a5", jtag_data); end
    checks++; if (vcount - v0 !== 1) begin errors++; $display("FAIL rescan_valid_cnt got %0d exp 1", vcount - v0); end
  endtask

  initial begin
    test_reset;
    test_user_dr;
    test_capture;
    test_bypass;
    test_ir_capture;
    test_reset_mid_shift;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop so a stuck run still ends with a report
  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
